// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// Contents: FSM state enum, opcode and funct3 constants, and the select
// encodings driven on pc_src, alu_src_a/b, alu_op and mem_to_reg.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] A_SRC_RS1   = 2'd0;
    localparam logic [1:0] A_SRC_PC    = 2'd1;
    localparam logic [1:0] A_SRC_OLDPC = 2'd2;

    localparam logic [1:0] B_SRC_RS2  = 2'd0;
    localparam logic [1:0] B_SRC_IMM  = 2'd1;
    localparam logic [1:0] B_SRC_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_CMP   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition resolver: decides taken/not-taken from funct3 and ALU flags.
// Ports: funct3 (branch kind), alu_zero, alu_lt (signed A<B) -> taken.
// Purely combinational; unsupported funct3 values are never taken.
module branch_resolve
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = ~alu_zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = ~alu_lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing controller for the multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/WB).
// Ports: start/opcode/funct3/ALU flags/mem_ready in; memory, datapath enables and
// mux selects, busy, sticky err and cycle/retire counters out.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             oldpc_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             aluout_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    // Value the wait counter holds on the last allowed waiting cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              err_q, err_d;
    logic              retire;
    logic              br_taken;

    branch_resolve u_branch_resolve (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .taken    (br_taken)
    );

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        oldpc_write  = 1'b0;
        alu_src_a    = A_SRC_RS1;
        alu_src_b    = B_SRC_RS2;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = WB_ALUOUT;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = A_SRC_PC;
                alu_src_b = B_SRC_FOUR;
                if (mem_ready) begin
                    ir_write    = 1'b1;
                    oldpc_write = 1'b1;
                    pc_write    = 1'b1;
                    state_d     = ST_DECODE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                // Speculatively compute the branch/JAL target from OldPC.
                alu_src_a    = A_SRC_OLDPC;
                alu_src_b    = B_SRC_IMM;
                aluout_write = 1'b1;
                state_d      = is_legal_op(opcode) ? ST_EXEC : ST_ERR;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_R, OP_I: begin
                        alu_src_b    = (opcode == OP_I) ? B_SRC_IMM : B_SRC_RS2;
                        alu_op       = ALU_FUNCT;
                        aluout_write = 1'b1;
                        state_d      = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b    = B_SRC_IMM;
                        aluout_write = 1'b1;
                        state_d      = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op = ALU_CMP;
                        if (br_taken) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_ALUOUT;
                        end
                        retire = 1'b1;
                    end
                    OP_JAL: begin
                        // PC already holds OldPC+4, which is the link value.
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_ALUOUT;
                        reg_write  = 1'b1;
                        mem_to_reg = WB_PC;
                        retire     = 1'b1;
                    end
                    OP_JALR: begin
                        alu_src_b  = B_SRC_IMM;
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_JALR;
                        reg_write  = 1'b1;
                        mem_to_reg = WB_PC;
                        retire     = 1'b1;
                    end
                    default: state_d = ST_ERR;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) retire = 1'b1;
                    else                    state_d = ST_WB;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
                retire     = 1'b1;
            end
            default: state_d = ST_ERR;
        endcase

        // Instruction boundary: a low start parks the FSM here.
        if (retire) state_d = start ? ST_FETCH : ST_IDLE;
    end

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign err         = err_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

    assign to_cnt_d  = (mem_req && !mem_ready) ? (to_cnt_q + TO_W'(1)) : '0;
    assign cycle_d   = busy ? (cycle_q + CNT_W'(1)) : cycle_q;
    assign instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
    assign err_d     = err_q | (state_d == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            to_cnt_q  <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        alu_zero = 1'b0;
    logic        alu_lt = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, iord, ir_write, pc_write, oldpc_write;
    logic        aluout_write, reg_write, busy, err;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic [31:0] cycle_cnt, instret_cnt;

    int total = 0;
    int bad = 0;
    int exp_instret = 0;
    int exp_cycles = 0;

    multicycle_ctrl_fsm #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .funct3       (funct3),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .oldpc_write  (oldpc_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .aluout_write (aluout_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .busy         (busy),
        .err          (err),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       lt;
        int         cyc;    // busy cycles from IDLE exit to return
        int         rw;     // reg_write pulses
        int         m2r;    // mem_to_reg on the reg_write pulse
        int         redir;  // pc_write pulses with a non-sequential pc_src
        int         rsrc;   // pc_src on that redirect
        int         mreq;   // cycles with mem_req high
        int         mwe;    // cycles with mem_req & mem_we
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                input logic lt, input int cyc, input int rw, input int m2r,
                                input int redir, input int rsrc, input int mreq, input int mwe);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.lt = lt; v.cyc = cyc; v.rw = rw; v.m2r = m2r;
        v.redir = redir; v.rsrc = rsrc; v.mreq = mreq; v.mwe = mwe;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int ctrl_sum();
        return int'(mem_req) + int'(mem_we) + int'(iord) + int'(ir_write) + int'(pc_write) +
               int'(oldpc_write) + int'(aluout_write) + int'(reg_write) + int'(pc_src) +
               int'(alu_src_a) + int'(alu_src_b) + int'(alu_op) + int'(mem_to_reg);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 0;
        exp_cycles = 0;
    endtask

    // Runs a single instruction from IDLE with start pulsed for one cycle.
    task automatic run_one(input vec_t v, output int cyc, output int rw, output int m2r,
                           output int redir, output int rsrc, output int mreq, output int mwe);
        cyc = 0; rw = 0; m2r = 0; redir = 0; rsrc = 0; mreq = 0; mwe = 0;
        @(negedge clk);
        opcode = v.op; funct3 = v.f3; alu_zero = v.z; alu_lt = v.lt;
        mem_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            cyc++;
            if (reg_write) begin rw++; m2r = int'(mem_to_reg); end
            if (pc_write && pc_src != 2'd0) begin redir++; rsrc = int'(pc_src); end
            if (mem_req) mreq++;
            if (mem_req && mem_we) mwe++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, rw, m2r, redir, rsrc, mreq, mwe;
        int first, last, mcyc, frozen_bad, ctrl_bad, snap_c, snap_i;

        // op, f3, z, lt, cyc, rw, m2r, redir, rsrc, mreq, mwe
        tbl[0]  = mk(7'b0110011, 3'b000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 1, 0); // ADD
        tbl[1]  = mk(7'b0010011, 3'b000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 1, 0); // ADDI
        tbl[2]  = mk(7'b0000011, 3'b010, 1'b0, 1'b0, 5, 1, 1, 0, 0, 2, 0); // LW
        tbl[3]  = mk(7'b0100011, 3'b010, 1'b0, 1'b0, 4, 0, 0, 0, 0, 2, 1); // SW
        tbl[4]  = mk(7'b1100011, 3'b000, 1'b1, 1'b0, 3, 0, 0, 1, 1, 1, 0); // BEQ taken
        tbl[5]  = mk(7'b1100011, 3'b000, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1, 0); // BEQ not taken
        tbl[6]  = mk(7'b1100011, 3'b001, 1'b0, 1'b0, 3, 0, 0, 1, 1, 1, 0); // BNE taken
        tbl[7]  = mk(7'b1100011, 3'b100, 1'b0, 1'b1, 3, 0, 0, 1, 1, 1, 0); // BLT taken
        tbl[8]  = mk(7'b1100011, 3'b101, 1'b0, 1'b1, 3, 0, 0, 0, 0, 1, 0); // BGE not taken
        tbl[9]  = mk(7'b1100011, 3'b010, 1'b1, 1'b1, 3, 0, 0, 0, 0, 1, 0); // bad funct3
        tbl[10] = mk(7'b1101111, 3'b000, 1'b0, 1'b0, 3, 1, 2, 1, 1, 1, 0); // JAL
        tbl[11] = mk(7'b1100111, 3'b000, 1'b0, 1'b0, 3, 1, 2, 1, 2, 1, 0); // JALR

        // Reset state, sampled while reset is held.
        repeat (2) @(negedge clk);
        chk("rst ctrl", ctrl_sum(), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst err", int'(err), 0);
        chk("rst cycle_cnt", int'(cycle_cnt), 0);
        chk("rst instret", int'(instret_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", int'(busy), 0);

        foreach (tbl[i]) begin
            run_one(tbl[i], cyc, rw, m2r, redir, rsrc, mreq, mwe);
            exp_instret++;
            exp_cycles += tbl[i].cyc;
            chk($sformatf("v%0d cycles", i), cyc, tbl[i].cyc);
            chk($sformatf("v%0d reg_write", i), rw, tbl[i].rw);
            chk($sformatf("v%0d mem_to_reg", i), m2r, tbl[i].m2r);
            chk($sformatf("v%0d redirect", i), redir, tbl[i].redir);
            chk($sformatf("v%0d pc_src", i), rsrc, tbl[i].rsrc);
            chk($sformatf("v%0d mem_req", i), mreq, tbl[i].mreq);
            chk($sformatf("v%0d mem_we", i), mwe, tbl[i].mwe);
            chk($sformatf("v%0d instret", i), int'(instret_cnt), exp_instret);
            chk($sformatf("v%0d cycle_cnt", i), int'(cycle_cnt), exp_cycles);
        end

        // LW with memory stalling 3 cycles in MEM.
        @(negedge clk);
        opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; rw = 0; m2r = 0; mcyc = 0; first = -1; last = -1;
        for (int k = 0; k < 30; k++) begin
            if (!busy) break;
            cyc++;
            if (mem_req && iord) begin
                mem_ready = (mcyc >= 3);
                mcyc++;
                if (first < 0) first = cyc;
                last = cyc;
            end else begin
                mem_ready = 1'b1;
            end
            if (reg_write) begin rw++; m2r = int'(mem_to_reg); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        exp_instret++;
        exp_cycles += 8;
        chk("lw_stall mem cycles", mcyc, 4);
        chk("lw_stall contiguous", last - first + 1, 4);
        chk("lw_stall total", cyc, 8);
        chk("lw_stall reg_write", rw, 1);
        chk("lw_stall mem_to_reg", m2r, 1);
        chk("lw_stall instret", int'(instret_cnt), exp_instret);
        chk("lw_stall cycle_cnt", int'(cycle_cnt), exp_cycles);

        // SW with start dropped in EXEC: completes, retires, parks in IDLE.
        @(negedge clk);
        opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            cyc++;
            if (cyc == 3) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        exp_instret++;
        exp_cycles += 4;
        chk("sw_stop cycles", cyc, 4);
        chk("sw_stop instret", int'(instret_cnt), exp_instret);
        mreq = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_req || busy) mreq++;
            @(negedge clk);
        end
        chk("sw_stop parked", mreq, 0);

        // Illegal opcode: ERR after DECODE, everything frozen until reset.
        @(negedge clk);
        opcode = 7'h7F; funct3 = 3'b000; mem_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            cyc++;
            @(negedge clk);
        end
        exp_cycles += 2;
        chk("illegal busy cycles", cyc, 2);
        chk("illegal err", int'(err), 1);
        chk("illegal cycle_cnt", int'(cycle_cnt), exp_cycles);
        snap_c = int'(cycle_cnt);
        snap_i = int'(instret_cnt);
        frozen_bad = 0; ctrl_bad = 0;
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!err || busy || int'(cycle_cnt) != snap_c || int'(instret_cnt) != snap_i)
                frozen_bad++;
            if (ctrl_sum() != 0) ctrl_bad++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("err frozen", frozen_bad, 0);
        chk("err ctrl zero", ctrl_bad, 0);
        chk("err instret", snap_i, exp_instret);
        rst = 1'b1;
        #1;
        chk("rst clr err", int'(err), 0);
        chk("rst clr cycle_cnt", int'(cycle_cnt), 0);
        chk("rst clr instret", int'(instret_cnt), 0);
        chk("rst clr busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 0;
        exp_cycles = 0;

        // FETCH timeout with memory never ready.
        @(negedge clk);
        opcode = 7'b0110011; mem_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mcyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (!mem_req) break;
            mcyc++;
            @(negedge clk);
        end
        chk("timeout wait cycles", mcyc, 4);
        chk("timeout err", int'(err), 1);
        chk("timeout mem_req", int'(mem_req), 0);
        chk("timeout cycle_cnt", int'(cycle_cnt), 4);
        do_reset();
        chk("post-timeout err", int'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
